knock_unlock_ctrl: RTL and testbench

//   Bus-snooping unlock sequencer for the serial-data (SD) read port in the BA13=0/BA12=1 window.
//   - Tracks a programmable sequence of read "knocks"; each knock is matched on address nibble BA[7:4].
//   - Once the full sequence matches, the block streams a fixed data word out on the SD line, one bit per window read.
//   - After the stream completes, or on an abort or timeout, the block relocks.
//   - Sits beside the bus decode; its outputs drive the tri-state SD buffer enable and data.

---
 rtl/knock_pkg.sv | 25 ++
 rtl/knock_timeout_ctr.sv | 35 +++
 rtl/knock_unlock_ctrl.sv | 140 ++++++++++++++
 tb/tb_knock_unlock_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/knock_pkg.sv
// knock_pkg: shared types and constants for the knock unlock sequencer.
//   - knock_state_e : FSM states (LOCKED, STREAM)
//   - NIB_W, WIN_HI : knock nibble width and {BA13,BA12} window decode
//   - LFSR_SEED/LFSR_TAPS : scrambler seed and feedback mask (used only when
//     KNOCK_SCRAMBLE_EN is defined)
//   - key_nib()     : extracts knock nibble idx from the packed key
package knock_pkg;

  typedef enum logic {
    LOCKED = 1'b0,
    STREAM = 1'b1
  } knock_state_e;

  localparam int         NIB_W     = 4;
  localparam logic [1:0] WIN_HI    = 2'b01;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 on a left-shifting register: stages 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Packed key holds nibbles LSB-first; idx selects one 4-bit knock.
  function automatic logic [NIB_W-1:0] key_nib(input logic [31:0] key, input logic [2:0] idx);
    key_nib = key[{idx, 2'b00} +: NIB_W];
  endfunction

endpackage

// File: rtl/knock_timeout_ctr.sv
// knock_timeout_ctr: saturating idle counter for forced relock.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the count (window read hit)
//   en         : count this clock (sequence armed or streaming)
//   expired    : the count reaches TIMEOUT_CYC on this clock edge
module knock_timeout_ctr #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] idle_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
    end else if (clr) begin
      idle_cnt_reg <= '0;
    end else if (en && (idle_cnt_reg != LIMIT)) begin
      idle_cnt_reg <= idle_cnt_reg + CW'(1);
    end
  end

  // Flag the edge on which the count arrives at LIMIT so the relock lands on
  // the same edge; a clearing hit in that cycle wins.
  assign expired = en & ~clr & (idle_cnt_reg >= (LIMIT - CW'(1)));

endmodule

// File: rtl/knock_unlock_ctrl.sv
// knock_unlock_ctrl: bus-snooping unlock sequencer for the SD read window
// (BA13=0, BA12=1). A programmed series of read knocks matched on BA[7:4]
// unlocks the block, which then streams DATA_WORD LSB-first on SD, one bit
// per window read, and relocks after the last bit, a window write, or an
// idle timeout.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus_strobe, bus_rw  : bus cycle valid pulse, 1=read
//   sser                : serial-space inhibit (window needs sser=0)
//   ba_hi, ba_nib       : {BA13,BA12}, BA[7:4]
//   unlocked            : high while streaming
//   seq_pos             : knocks matched so far (0 while streaming)
//   sd_oe, sd_o         : registered SD buffer enable and data
// Optional: define KNOCK_SCRAMBLE_EN to XOR each streamed bit with an 8-bit
// LFSR seeded with 8'hA5 on every unlock.
module knock_unlock_ctrl
  import knock_pkg::*;
#(
  parameter int                   SEQ_LEN     = 4,
  parameter logic [4*SEQ_LEN-1:0] KEY         = 16'hA9A2,
  parameter int                   DATA_BITS   = 16,
  parameter logic [DATA_BITS-1:0] DATA_WORD   = 16'hC35A,
  parameter int                   TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bus_strobe,
  input  logic       bus_rw,
  input  logic       sser,
  input  logic [1:0] ba_hi,
  input  logic [3:0] ba_nib,
  output logic       unlocked,
  output logic [2:0] seq_pos,
  output logic       sd_oe,
  output logic       sd_o
);

  localparam logic [31:0] KEY_EXT  = 32'(KEY);
  localparam logic [31:0] DATA_EXT = 32'(DATA_WORD);

  knock_state_e state_reg;
  logic [2:0]   pos_reg;
  logic [4:0]   bit_idx_reg;
  logic         win;
  logic         whit;
  logic         wwr;
  logic         tmo_en;
  logic         tmo_expired;
  logic         sd_bit;

`ifdef KNOCK_SCRAMBLE_EN
  logic [7:0] lfsr_reg;
  assign sd_bit = DATA_EXT[bit_idx_reg] ^ lfsr_reg[0];
`else
  assign sd_bit = DATA_EXT[bit_idx_reg];
`endif

  assign win     = bus_strobe & ~sser & (ba_hi == WIN_HI);
  assign whit    = win & bus_rw;
  assign wwr     = win & ~bus_rw;
  assign tmo_en  = (state_reg == STREAM) | (pos_reg != 3'd0);
  assign seq_pos = pos_reg;

  knock_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (whit),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= LOCKED;
      pos_reg     <= 3'd0;
      bit_idx_reg <= 5'd0;
      unlocked    <= 1'b0;
      sd_oe       <= 1'b0;
      sd_o        <= 1'b0;
`ifdef KNOCK_SCRAMBLE_EN
      lfsr_reg    <= LFSR_SEED;
`endif
    end else begin
      // Enable is a single-clock pulse per served read; sd_o holds otherwise.
      sd_oe <= 1'b0;
      if (wwr) begin
        state_reg   <= LOCKED;
        unlocked    <= 1'b0;
        pos_reg     <= 3'd0;
        bit_idx_reg <= 5'd0;
      end else if (whit) begin
        case (state_reg)
          LOCKED: begin
            if (ba_nib == key_nib(KEY_EXT, pos_reg)) begin
              if (pos_reg == 3'(SEQ_LEN - 1)) begin
                state_reg   <= STREAM;
                unlocked    <= 1'b1;
                pos_reg     <= 3'd0;
                bit_idx_reg <= 5'd0;
`ifdef KNOCK_SCRAMBLE_EN
                lfsr_reg    <= LFSR_SEED;
`endif
              end else begin
                pos_reg <= pos_reg + 3'd1;
              end
            end else begin
              // A wrong knock may itself be the first knock of a new attempt.
              pos_reg <= (ba_nib == key_nib(KEY_EXT, 3'd0)) ? 3'd1 : 3'd0;
            end
          end
          STREAM: begin
            sd_oe <= 1'b1;
            sd_o  <= sd_bit;
`ifdef KNOCK_SCRAMBLE_EN
            lfsr_reg <= {lfsr_reg[6:0], ^(lfsr_reg & LFSR_TAPS)};
`endif
            if (bit_idx_reg == 5'(DATA_BITS - 1)) begin
              state_reg   <= LOCKED;
              unlocked    <= 1'b0;
              bit_idx_reg <= 5'd0;
            end else begin
              bit_idx_reg <= bit_idx_reg + 5'd1;
            end
          end
          default: begin
            state_reg <= LOCKED;
            unlocked  <= 1'b0;
          end
        endcase
      end else if (tmo_expired) begin
        state_reg   <= LOCKED;
        unlocked    <= 1'b0;
        pos_reg     <= 3'd0;
        bit_idx_reg <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_knock_unlock_ctrl.sv
// tb_knock_unlock_ctrl: directed stimulus for knock_unlock_ctrl with a
// per-cycle behavioural reference model and hand-computed checkpoints.
// Define KNOCK_SCRAMBLE_EN for both bench and RTL to exercise the scrambler.
`timescale 1ns/1ps
module tb_knock_unlock_ctrl;

  localparam int SEQ_LEN   = 4;
  localparam int DATA_BITS = 16;
  localparam int TMO       = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_strobe = 1'b0;
  logic       bus_rw = 1'b0;
  logic       sser = 1'b0;
  logic [1:0] ba_hi = 2'b00;
  logic [3:0] ba_nib = 4'h0;
  logic       unlocked;
  logic [2:0] seq_pos;
  logic       sd_oe;
  logic       sd_o;

  int  n_vec  = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;

  int          key_q[SEQ_LEN] = '{2, 10, 9, 10};
  logic [15:0] word = 16'hC35A;
  logic [15:0] exp_word;
  logic [15:0] got;

  // reference model state
  bit          m_unl = 1'b0;
  int          m_pos = 0;
  int          m_bit = 0;
  int          m_idle = 0;
  bit          m_oe = 1'b0;
  bit          m_o = 1'b0;
  logic [7:0]  m_lfsr = 8'hA5;

  knock_unlock_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_strobe(bus_strobe),
    .bus_rw    (bus_rw),
    .sser      (sser),
    .ba_hi     (ba_hi),
    .ba_nib    (ba_nib),
    .unlocked  (unlocked),
    .seq_pos   (seq_pos),
    .sd_oe     (sd_oe),
    .sd_o      (sd_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the behavioural rules to the inputs seen at
  // each rising edge.
  initial begin
    bit hit, wr, armed;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_unl = 0; m_pos = 0; m_bit = 0; m_idle = 0;
        m_oe = 0; m_o = 0; m_lfsr = 8'hA5;
      end else begin
        hit   = bus_strobe && !sser && ba_hi == 2'b01 && bus_rw;
        wr    = bus_strobe && !sser && ba_hi == 2'b01 && !bus_rw;
        armed = m_unl || (m_pos != 0);
        m_oe  = 0;
        if (hit) m_idle = 0;
        else if (armed && m_idle < TMO) m_idle++;
        if (wr) begin
          m_unl = 0; m_pos = 0; m_bit = 0;
        end else if (hit) begin
          if (m_unl) begin
            m_oe = 1;
`ifdef KNOCK_SCRAMBLE_EN
            m_o = word[m_bit] ^ m_lfsr[0];
            m_lfsr = lfsr_next(m_lfsr);
`else
            m_o = word[m_bit];
`endif
            m_bit++;
            if (m_bit == DATA_BITS) begin
              m_unl = 0; m_bit = 0;
            end
          end else if (int'(ba_nib) == key_q[m_pos]) begin
            m_pos++;
            if (m_pos == SEQ_LEN) begin
              m_unl = 1; m_pos = 0; m_bit = 0; m_lfsr = 8'hA5;
            end
          end else begin
            m_pos = (int'(ba_nib) == key_q[0]) ? 1 : 0;
          end
        end else if (armed && m_idle == TMO) begin
          m_unl = 0; m_pos = 0; m_bit = 0;
        end
      end
    end
  end

  // Cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        chk("model_unlocked", int'(unlocked), int'(m_unl));
        chk("model_seq_pos", int'(seq_pos), m_pos);
        chk("model_sd_oe", int'(sd_oe), int'(m_oe));
        chk("model_sd_o", int'(sd_o), int'(m_o));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // One bus cycle: strobe valid for exactly one rising edge.
  task automatic bus(input logic rw, input logic s, input logic [1:0] hi, input logic [3:0] nib);
    @(negedge clk);
    bus_strobe = 1'b1; bus_rw = rw; sser = s; ba_hi = hi; ba_nib = nib;
    @(negedge clk);
    bus_strobe = 1'b0;
    $display("txn t=%0t rw=%0b sser=%0b hi=%b nib=%h -> unlocked=%0b seq_pos=%0d sd_oe=%0b sd_o=%0b",
             $time, rw, s, hi, nib, unlocked, seq_pos, sd_oe, sd_o);
  endtask

  task automatic rd(input logic [3:0] nib);
    bus(1'b1, 1'b0, 2'b01, nib);
  endtask

  task automatic wr_win();
    bus(1'b0, 1'b0, 2'b01, 4'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic unlock_seq();
    for (int i = 0; i < SEQ_LEN; i++) rd(4'(key_q[i]));
  endtask

  initial begin
    // expected stream word
`ifdef KNOCK_SCRAMBLE_EN
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i < DATA_BITS; i++) begin
      exp_word[i] = word[i] ^ l[0];
      l = lfsr_next(l);
    end
`else
    exp_word = 16'hC35A;
`endif

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(1);
    chk("reset_unlocked", int'(unlocked), 0);
    chk("reset_seq_pos", int'(seq_pos), 0);
    chk("reset_sd_oe", int'(sd_oe), 0);
    chk("reset_sd_o", int'(sd_o), 0);

    // basic unlock and full stream
    rd(4'h2); rd(4'hA); rd(4'h9);
    chk("t2_pos3", int'(seq_pos), 3);
    chk("t2_not_yet", int'(unlocked), 0);
    rd(4'hA);
    chk("t2_unlocked", int'(unlocked), 1);
    chk("t2_pos_stream", int'(seq_pos), 0);
    got = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      rd(4'h0);
      chk("t2_oe_on_read", int'(sd_oe), 1);
      got[i] = sd_o;
      if (i == 7) idle(3);
      if (i == DATA_BITS - 2) chk("t2_unlocked_before_last", int'(unlocked), 1);
    end
    chk("t2_stream_word", int'(got), int'(exp_word));
`ifdef KNOCK_SCRAMBLE_EN
    chk("t6_first_bit", int'(got[0]), 1);
`endif
    chk("t2_relock", int'(unlocked), 0);
    idle(1);
    chk("t2_oe_pulse", int'(sd_oe), 0);

    // restart-aware mismatch
    rd(4'h2); rd(4'hA);
    chk("t3_pos2", int'(seq_pos), 2);
    rd(4'h2);
    chk("t3_restart_pos1", int'(seq_pos), 1);
    rd(4'hA); rd(4'h9);
    chk("t3_no_unlock5", int'(unlocked), 0);
    rd(4'hA);
    chk("t3_unlock6", int'(unlocked), 1);
    wr_win();
    chk("t3_abort", int'(unlocked), 0);
    rd(4'h2); rd(4'hA); rd(4'h5);
    chk("t3_bad_pos0", int'(seq_pos), 0);

    // timeout boundary, then write abort mid-stream
    rd(4'h2); rd(4'hA);
    idle(TMO - 1);
    chk("t4_pos_before_tmo", int'(seq_pos), 2);
    idle(1);
    chk("t4_pos_after_tmo", int'(seq_pos), 0);
    unlock_seq();
    rd(4'h0); rd(4'h0); rd(4'h0);
    chk("t4_stream_live", int'(unlocked), 1);
    wr_win();
    chk("t4_wr_unlocked", int'(unlocked), 0);
    chk("t4_wr_oe", int'(sd_oe), 0);
    idle(1);
    chk("t4_wr_oe_after", int'(sd_oe), 0);
    rd(4'h2);
    chk("t4_relocked_pos1", int'(seq_pos), 1);
    wr_win();
    chk("t4_wr_clears_pos", int'(seq_pos), 0);

    // out-of-window strobes are ignored
    rd(4'h2);
    bus(1'b1, 1'b1, 2'b01, 4'h5);
    bus(1'b1, 1'b0, 2'b11, 4'h5);
    bus(1'b0, 1'b1, 2'b01, 4'h0);
    bus(1'b0, 1'b0, 2'b11, 4'h0);
    rd(4'hA);
    chk("t5_pos2", int'(seq_pos), 2);
    rd(4'h9);
    bus(1'b1, 1'b0, 2'b00, 4'h1);
    bus(1'b0, 1'b0, 2'b10, 4'h0);
    rd(4'hA);
    chk("t5_unlock", int'(unlocked), 1);

    // asynchronous reset mid-stream
    rd(4'h0); rd(4'h0);
    chk("t1_pre_unlocked", int'(unlocked), 1);
    chk("t1_pre_sd_o", int'(sd_o), int'(exp_word[1]));
    #2;
    rst_n = 1'b0;
    #0.5;
    chk("t1_rst_unlocked", int'(unlocked), 0);
    chk("t1_rst_sd_oe", int'(sd_oe), 0);
    chk("t1_rst_sd_o", int'(sd_o), 0);
    chk("t1_rst_seq_pos", int'(seq_pos), 0);
    #0.5;
    rst_n = 1'b1;
    unlock_seq();
    rd(4'h0);
    chk("t1_first_bit_after_rst", int'(sd_o), int'(exp_word[0]));
    idle(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
